branch_resolver: RTL and testbench

- Producer side of the program-counter redirect interface. Evaluates decoded branch/jump instructions against the processor condition flags.
- Emits the one-cycle wBranchTaken / wJumpTaken / wBranchAddress requests consumed by the PC decider.
- Squashes the instructions already fetched in the branch shadow.
- Keeps a running count of taken redirects for debug.

---
 rtl/branch_resolver_pkg.sv | 14 +
 rtl/branch_resolver_cond_eval.sv | 25 ++
 rtl/branch_resolver.sv | 78 +++++++
 tb/tb_branch_resolver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: condition codes, offset field layout and FSM states shared by the redirect logic.
package branch_resolver_pkg;
    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_N      = 3'd3;
    localparam logic [2:0] COND_NN     = 3'd4;
    localparam logic [2:0] COND_C      = 3'd5;
    localparam logic [2:0] COND_NC     = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;
    localparam int OFF_DIR_BIT = 5;
    localparam int OFF_MAG_W   = 5;
    typedef enum logic {ST_RUN = 1'b0, ST_SHADOW = 1'b1} state_e;
endpackage

// File: rtl/branch_resolver_cond_eval.sv
// branch_resolver_cond_eval: decides whether a condition code holds for the given Z/N/C flags.
module branch_resolver_cond_eval
    import branch_resolver_pkg::*;
(
    input  logic [2:0] iCond,
    input  logic       iZ,
    input  logic       iN,
    input  logic       iC,
    output logic       oTrue
);
    always_comb begin
        oTrue = 1'b0;
        case (iCond)
            COND_ALWAYS: oTrue = 1'b1;
            COND_Z:      oTrue = iZ;
            COND_NZ:     oTrue = !iZ;
            COND_N:      oTrue = iN;
            COND_NN:     oTrue = !iN;
            COND_C:      oTrue = iC;
            COND_NC:     oTrue = !iC;
            COND_NEVER:  oTrue = 1'b0;
            default:     oTrue = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: turns decoded jumps/branches into one-cycle PC redirect pulses,
// squashes the fetched shadow behind each redirect and counts redirects.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int OFF_W  = 6,
    parameter int SHADOW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              iValid,
    input  logic              iIsJump,
    input  logic              iIsBranch,
    input  logic [2:0]        iCond,
    input  logic [ADDR_W-1:0] iTarget,
    input  logic [OFF_W-1:0]  iOffset,
    input  logic              iFlagWe,
    input  logic              iZero,
    input  logic              iNeg,
    input  logic              iCarry,
    output logic              wBranchTaken,
    output logic              wJumpTaken,
    output logic [ADDR_W-1:0] wBranchAddress,
    output logic              oSquash,
    output logic [CNT_W-1:0]  oTakenCount
);
    localparam logic [2:0] SH = 3'(SHADOW);
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        flag_q;
    logic              jt_q, jt_d, bt_q, bt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  taken_q;
    logic              bz, bn, bc, cond_true, run;
    // Flags written this cycle are visible to the branch in the same cycle.
    assign {bz, bn, bc} = iFlagWe ? {iZero, iNeg, iCarry} : flag_q;
    branch_resolver_cond_eval u_cond_eval (
        .iCond (iCond),
        .iZ    (bz),
        .iN    (bn),
        .iC    (bc),
        .oTrue (cond_true)
    );
    assign run = state_q == ST_RUN;
    always_comb begin
        jt_d    = run && iValid && iIsJump;
        bt_d    = run && iValid && !iIsJump && iIsBranch && cond_true;
        addr_d  = jt_d ? iTarget : bt_d ? ADDR_W'(iOffset) : '0;
        state_d = run ? ((jt_d || bt_d) ? ST_SHADOW : ST_RUN) : (cnt_q == 3'd1 ? ST_RUN : ST_SHADOW);
        cnt_d   = run ? SH : cnt_q - 3'd1;
    end
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            flag_q  <= '0;
            jt_q    <= 1'b0;
            bt_q    <= 1'b0;
            addr_q  <= '0;
            taken_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= iFlagWe ? {iZero, iNeg, iCarry} : flag_q;
            jt_q    <= jt_d;
            bt_q    <= bt_d;
            addr_q  <= addr_d;
            taken_q <= taken_q + CNT_W'(jt_d || bt_d);
        end
    end
    assign wJumpTaken     = jt_q;
    assign wBranchTaken   = bt_q;
    assign wBranchAddress = addr_q;
    assign oSquash        = iValid && !run;
    assign oTakenCount    = taken_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and random stimulus checked every cycle against an interval-based model.
module tb_branch_resolver;
    localparam int SHADOW = 2;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       iValid = 0, iIsJump = 0, iIsBranch = 0, iFlagWe = 0, iZero = 0, iNeg = 0, iCarry = 0;
    logic [2:0] iCond = 0;
    logic [9:0] iTarget = 0;
    logic [5:0] iOffset = 0;
    logic       wBranchTaken, wJumpTaken, oSquash;
    logic [9:0] wBranchAddress;
    logic [15:0] oTakenCount;

    logic       v2 = 0, j2 = 0;
    logic       jt2, bt2, sq2;
    logic [9:0] addr2;
    logic [3:0] cnt2;
    logic       z0 = 1'b0;
    logic [2:0] z3 = '0;
    logic [9:0] t2 = 10'h1C3;
    logic [5:0] z6 = '0;

    int total = 0, bad = 0;

    branch_resolver #(.ADDR_W(10), .OFF_W(6), .SHADOW(SHADOW), .CNT_W(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .iValid(iValid), .iIsJump(iIsJump), .iIsBranch(iIsBranch),
        .iCond(iCond), .iTarget(iTarget), .iOffset(iOffset), .iFlagWe(iFlagWe), .iZero(iZero),
        .iNeg(iNeg), .iCarry(iCarry), .wBranchTaken(wBranchTaken), .wJumpTaken(wJumpTaken),
        .wBranchAddress(wBranchAddress), .oSquash(oSquash), .oTakenCount(oTakenCount)
    );

    branch_resolver #(.ADDR_W(10), .OFF_W(6), .SHADOW(1), .CNT_W(4)) dut2 (
        .Clock(Clock), .Reset_n(Reset_n), .iValid(v2), .iIsJump(j2), .iIsBranch(z0),
        .iCond(z3), .iTarget(t2), .iOffset(z6), .iFlagWe(z0), .iZero(z0),
        .iNeg(z0), .iCarry(z0), .wBranchTaken(bt2), .wJumpTaken(jt2),
        .wBranchAddress(addr2), .oSquash(sq2), .oTakenCount(cnt2)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a redirect accepted in cycle k squashes cycles k+1..k+SHADOW.
    function automatic bit holds(input logic [2:0] cc, input bit z, input bit n, input bit c);
        bit f;
        if (cc == 3'd0) return 1'b1;
        if (cc == 3'd7) return 1'b0;
        f = (cc < 3) ? z : (cc < 5) ? n : c;
        return cc[0] ? f : !f;
    endfunction

    bit         mz = 0, mn = 0, mc = 0;
    bit         e_jt = 0, e_bt = 0;
    logic [9:0] e_addr = 0;
    logic [15:0] e_cnt = 0;
    int         cyc = 0, shadow_last = -1;
    bit         nj, nb, bz, bn, bc;

    always_comb begin
        bz = iFlagWe ? iZero : mz;
        bn = iFlagWe ? iNeg : mn;
        bc = iFlagWe ? iCarry : mc;
        nj = iValid && cyc > shadow_last && iIsJump;
        nb = iValid && cyc > shadow_last && !iIsJump && iIsBranch && holds(iCond, bz, bn, bc);
    end

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mz <= 0; mn <= 0; mc <= 0;
            e_jt <= 0; e_bt <= 0; e_addr <= 0; e_cnt <= 0;
            shadow_last <= -1;
        end else begin
            e_jt   <= nj;
            e_bt   <= nb;
            e_addr <= nj ? iTarget : nb ? {4'b0, iOffset} : 10'h0;
            if (nj || nb) begin
                shadow_last <= cyc + SHADOW;
                e_cnt <= e_cnt + 16'd1;
            end
            if (iFlagWe) begin
                mz <= iZero; mn <= iNeg; mc <= iCarry;
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge Clock) begin
        chk("m_jump", wJumpTaken, e_jt);
        chk("m_branch", wBranchTaken, e_bt);
        chk("m_addr", wBranchAddress, e_addr);
        chk("m_squash", oSquash, iValid && cyc <= shadow_last);
        chk("m_count", oTakenCount, e_cnt);
    end

    task automatic drv(input bit v, input bit j, input bit b, input logic [2:0] cc, input logic [9:0] t,
                       input logic [5:0] o, input bit we, input bit z, input bit n, input bit c);
        @(posedge Clock);
        #1;
        iValid = v; iIsJump = j; iIsBranch = b; iCond = cc; iTarget = t; iOffset = o;
        iFlagWe = we; iZero = z; iNeg = n; iCarry = c;
    endtask

    task automatic idle();
        drv(0, 0, 0, 3'd0, 10'h0, 6'h0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1 Reset_n = 1'b1;
        repeat (5) idle();
        chk("rst_jump", wJumpTaken, 0);
        chk("rst_branch", wBranchTaken, 0);
        chk("rst_addr", wBranchAddress, 0);
        chk("rst_count", oTakenCount, 0);

        drv(1, 1, 0, 3'd0, 10'h2A5, 6'h0, 0, 0, 0, 0);
        drv(1, 1, 0, 3'd0, 10'h3FF, 6'h0, 0, 0, 0, 0);
        chk("jmp_pulse", wJumpTaken, 1);
        chk("jmp_addr", wBranchAddress, 10'h2A5);
        chk("jmp_sq1", oSquash, 1);
        drv(1, 1, 0, 3'd0, 10'h3FF, 6'h0, 0, 0, 0, 0);
        chk("jmp_once", wJumpTaken, 0);
        chk("jmp_addr0", wBranchAddress, 0);
        chk("jmp_sq2", oSquash, 1);
        drv(1, 0, 0, 3'd0, 10'h0, 6'h0, 0, 0, 0, 0);
        chk("jmp_sq3", oSquash, 0);
        chk("jmp_count", oTakenCount, 1);
        idle();

        drv(1, 0, 1, 3'd1, 10'h0, 6'b100011, 1, 1, 0, 0);
        idle();
        chk("byp_taken", wBranchTaken, 1);
        chk("byp_addr", wBranchAddress, 10'h023);
        idle(); idle();
        drv(1, 0, 1, 3'd1, 10'h0, 6'b100011, 1, 0, 0, 0);
        drv(1, 0, 0, 3'd0, 10'h0, 6'h0, 0, 0, 0, 0);
        chk("nt_pulse", wBranchTaken, 0);
        chk("nt_addr", wBranchAddress, 0);
        chk("nt_squash", oSquash, 0);
        idle();

        drv(1, 1, 1, 3'd0, 10'h010, 6'h3F, 0, 0, 0, 0);
        idle();
        chk("pri_jump", wJumpTaken, 1);
        chk("pri_branch", wBranchTaken, 0);
        chk("pri_addr", wBranchAddress, 10'h010);
        chk("pri_count", oTakenCount, 3);
        idle(); idle();

        drv(1, 0, 1, 3'd1, 10'h0, 6'h01, 1, 1, 0, 0);
        drv(1, 0, 1, 3'd1, 10'h0, 6'h02, 0, 0, 0, 0);
        chk("b2b_taken", wBranchTaken, 1);
        chk("b2b_addr", wBranchAddress, 10'h001);
        chk("b2b_sq", oSquash, 1);
        drv(1, 0, 1, 3'd1, 10'h0, 6'h03, 0, 0, 0, 0);
        chk("b2b_nopulse", wBranchTaken, 0);
        chk("b2b_sq2", oSquash, 1);
        drv(1, 0, 1, 3'd1, 10'h0, 6'h04, 0, 0, 0, 0);
        chk("b2b_sq3", oSquash, 0);
        idle();
        chk("b2b_third", wBranchTaken, 1);
        chk("b2b_third_addr", wBranchAddress, 10'h004);
        chk("b2b_count", oTakenCount, 5);
        idle(); idle();

        drv(1, 1, 0, 3'd0, 10'h0AA, 6'h0, 0, 0, 0, 0);
        drv(1, 0, 0, 3'd0, 10'h0, 6'h0, 0, 0, 0, 0);
        chk("ar_sq_before", oSquash, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("ar_sq", oSquash, 0);
        chk("ar_jump", wJumpTaken, 0);
        chk("ar_addr", wBranchAddress, 0);
        chk("ar_count", oTakenCount, 0);
        @(posedge Clock);
        #1 Reset_n = 1'b1;
        drv(1, 1, 0, 3'd0, 10'h155, 6'h0, 0, 0, 0, 0);
        idle();
        chk("ar_after", wJumpTaken, 1);
        chk("ar_after_addr", wBranchAddress, 10'h155);
        idle(); idle();
        drv(1, 0, 1, 3'd2, 10'h0, 6'h05, 0, 0, 0, 0);
        idle();
        chk("ar_flags", wBranchTaken, 1);
        chk("ar_flags_addr", wBranchAddress, 10'h005);
        idle(); idle();

        for (int i = 0; i < 100; i++)
            drv(1, 0, 1, 3'd7, 10'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle();
        chk("never_count", oTakenCount, 2);
        chk("never_pulse", wBranchTaken, 0);

        for (int i = 0; i < 300; i++)
            drv(1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom), 10'($urandom),
                6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(); idle(); idle();

        for (int i = 0; i < 31; i++) begin
            @(posedge Clock);
            #1 v2 = 1; j2 = 1;
            if (i == 29) chk("wrap_15", cnt2, 15);
        end
        @(posedge Clock);
        #1 v2 = 0; j2 = 0;
        chk("wrap_0", cnt2, 0);
        chk("wrap_pulse", jt2, 1);
        chk("wrap_addr", addr2, 10'h1C3);
        chk("wrap_sq", sq2 | bt2, 0);
        repeat (2) @(posedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
